// File: rtl/usc_rv_pkg.sv
// Shared definitions for the usc_rv decode front-end: major opcodes that
// force serialisation, the instruction-buffer entry layout and the scheduler
// state encoding.
package usc_rv_pkg;

  localparam logic [6:0] USC_RV_OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] USC_RV_OPC_MISC_MEM = 7'b0001111;

  // Reference entry width for the PC. The scheduler packs the same field
  // order (opc, pc, acc_flt, pg_flt) for whatever PC_W it is built with.
  localparam int USC_RV_PC_W = 32;

  typedef struct packed {
    logic [31:0]            opc;
    logic [USC_RV_PC_W-1:0] pc;
    logic                   acc_flt;
    logic                   pg_flt;
  } ib_entry_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SER_WAIT = 2'd1,
    FLT_HOLD = 2'd2
  } dec_sched_st_e;

  // An op must issue alone when it is SYSTEM, FENCE/MISC-MEM or fetch-faulted.
  function automatic logic usc_rv_is_ser(input logic [31:0] opc,
                                         input logic        acc_flt,
                                         input logic        pg_flt);
    return (opc[6:0] == USC_RV_OPC_SYSTEM) || (opc[6:0] == USC_RV_OPC_MISC_MEM) ||
           acc_flt || pg_flt;
  endfunction

endpackage

// File: rtl/usc_rv_ib_fifo.sv
// Circular instruction buffer: single push, LANES read ports looking at
// head+0..head+LANES-1, variable pop count and a flush that empties it.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module usc_rv_ib_fifo #(
  parameter int DEPTH  = 8,
  parameter int LANES  = 2,
  parameter int DATA_W = 66,
  parameter int PW     = $clog2(LANES + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic [PW-1:0]                 pop_cnt_i,
  output logic [LANES-1:0][DATA_W-1:0]  rd_data_o,
  output logic [LANES-1:0]              rd_avail_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [AW:0]       count;
  logic              push_ok;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign push_ok = push_i && !full_o && !flush_i;

  // Pointer update: flush wins over push and pop; both return to the same slot.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(pop_cnt_i);
    end
  end

  // Entry storage is data-only; stale contents are never observed because
  // rd_avail_o masks everything past the write pointer.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data_i;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
    logic [AW-1:0] rd_idx;
    assign rd_idx         = rd_ptr_reg[AW-1:0] + AW'(gi);
    assign rd_data_o[gi]  = mem_reg[rd_idx];
    assign rd_avail_o[gi] = (count > (AW + 1)'(gi));
  end

endmodule

// File: rtl/usc_rv_dec_sched.sv
// Issue scheduler in front of the decode lanes: forms in-order groups of up
// to LANES ops from the buffer head, isolates serialising/faulted ops in
// lane 0 and then parks until completion (SYSTEM/FENCE) or redirect (fault).
module usc_rv_dec_sched
  import usc_rv_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int IB_DEPTH = 8,
  parameter int PC_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fe_vld_i,
  output logic                  fe_rdy_o,
  input  logic [31:0]           fe_opc_i,
  input  logic [PC_W-1:0]       fe_pc_i,
  input  logic                  fe_access_flt_i,
  input  logic                  fe_page_flt_i,
  output logic [LANES-1:0]      ib_vld_o,
  output logic [LANES*32-1:0]   ib_opc_o,
  output logic [LANES*PC_W-1:0] ib_pc_o,
  output logic [LANES-1:0]      ib_access_flt_o,
  output logic [LANES-1:0]      ib_page_flt_o,
  input  logic                  dsp_rdy_i,
  input  logic                  sys_cmpl_i,
  input  logic                  flush_i,
  output logic                  busy_o
);

  localparam int ENT_W = 32 + PC_W + 2;
  localparam int PW    = $clog2(LANES + 1);

  dec_sched_st_e                st_reg;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [LANES-1:0][ENT_W-1:0]  rd_data;
  logic [LANES-1:0]             rd_avail;
  logic [LANES-1:0][31:0]       lane_opc;
  logic [LANES-1:0][PC_W-1:0]   lane_pc;
  logic [LANES-1:0]             lane_acc;
  logic [LANES-1:0]             lane_pg;
  logic [LANES-1:0]             lane_ser;
  logic [LANES-1:0]             grp_vld;
  logic [PW-1:0]                grp_cnt;
  logic                         pop;

  assign fe_rdy_o = !fifo_full && !flush_i;
  assign pop      = dsp_rdy_i && (|grp_vld) && !flush_i;
  assign busy_o   = !fifo_empty || (st_reg != RUN);
  assign ib_vld_o = grp_vld;

  usc_rv_ib_fifo #(
    .DEPTH  (IB_DEPTH),
    .LANES  (LANES),
    .DATA_W (ENT_W),
    .PW     (PW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .push_i      (fe_vld_i && fe_rdy_o),
    .push_data_i ({fe_opc_i, fe_pc_i, fe_access_flt_i, fe_page_flt_i}),
    .pop_cnt_i   (pop ? grp_cnt : '0),
    .rd_data_o   (rd_data),
    .rd_avail_o  (rd_avail),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_opc[gi] = rd_data[gi][ENT_W-1 -: 32];
    assign lane_pc[gi]  = rd_data[gi][PC_W+1:2];
    assign lane_acc[gi] = rd_data[gi][1];
    assign lane_pg[gi]  = rd_data[gi][0];
    assign lane_ser[gi] = rd_avail[gi] &&
                          usc_rv_is_ser(lane_opc[gi], lane_acc[gi], lane_pg[gi]);

    assign ib_opc_o[32*gi +: 32]     = grp_vld[gi] ? lane_opc[gi] : '0;
    assign ib_pc_o[PC_W*gi +: PC_W]  = grp_vld[gi] ? lane_pc[gi]  : '0;
    assign ib_access_flt_o[gi]       = grp_vld[gi] && lane_acc[gi];
    assign ib_page_flt_o[gi]         = grp_vld[gi] && lane_pg[gi];
  end

  // Group formation: contiguous from lane 0; a SER op at the head goes alone,
  // a SER op further back closes the group in front of itself.
  always_comb begin
    grp_vld    = '0;
    grp_vld[0] = (st_reg == RUN) && rd_avail[0];
    for (int k = 1; k < LANES; k++) begin
      grp_vld[k] = grp_vld[k-1] && rd_avail[k] && !lane_ser[k-1] && !lane_ser[k];
    end
  end

  // Number of ops in the presented group (the pop amount when dispatch accepts).
  always_comb begin
    grp_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      grp_cnt = grp_cnt + PW'(grp_vld[k]);
    end
  end

  // Scheduler state: park after a SER op leaves; faults wait for the redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      st_reg <= RUN;
    end else if (flush_i) begin
      st_reg <= RUN;
    end else begin
      case (st_reg)
        RUN: begin
          if (pop && lane_ser[0]) begin
            st_reg <= (lane_acc[0] || lane_pg[0]) ? FLT_HOLD : SER_WAIT;
          end
        end
        SER_WAIT: if (sys_cmpl_i) st_reg <= RUN;
        FLT_HOLD: st_reg <= FLT_HOLD;
        default:  st_reg <= RUN;
      endcase
    end
  end

endmodule
